// File: rtl/nios_security_ram_arbiter.sv
// Two-master (Nios data master m0, IMU/I2C sample writer m1) round-robin arbiter for the 1250-word security RAM.
// Optional build macro RAM_ARB_ERRCNT_EN adds a saturating 16-bit err_count output.
module nios_security_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int BE_W   = DATA_W / 8,
    parameter int DEPTH  = 1250
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
`ifdef RAM_ARB_ERRCNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDCAP  = 2'd2,
        RDRESP = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Unsigned compare on the full address width; one extra bit keeps DEPTH representable.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= DEPTH_C);
    endfunction

    state_t state_r;
    state_t state_s;
    logic   grant_r;
    logic   grant_s;
    logic   last_grant_r;
    logic   last_grant_s;
    logic   is_wr_r;
    logic   is_wr_s;
    logic   oor_r;
    logic   oor_s;
    logic   req0_s;
    logic   req1_s;
    logic   oor0_s;
    logic   oor1_s;
    logic   wait0_s;
    logic   wait1_s;
    logic   err0_s;
    logic   err1_s;

    assign req0_s    = m0_read | m0_write;
    assign req1_s    = m1_read | m1_write;
    assign oor0_s    = out_of_range(m0_address);
    assign oor1_s    = out_of_range(m1_address);
    assign ram_clken = 1'b1;

    // FSM state and latched transaction attributes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            is_wr_r      <= 1'b0;
            oor_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            is_wr_r      <= is_wr_s;
            oor_r        <= oor_s;
        end
    end

    // Next-state, arbitration and next values of the registered handshake outputs.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        is_wr_s      = is_wr_r;
        oor_s        = oor_r;
        wait0_s      = 1'b1;
        wait1_s      = 1'b1;
        err0_s       = 1'b0;
        err1_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_s || req1_s) begin
                    if (req0_s && req1_s) begin
                        grant_s = ~last_grant_r;
                    end else if (req0_s) begin
                        grant_s = 1'b0;
                    end else begin
                        grant_s = 1'b1;
                    end
                    last_grant_s = grant_s;
                    // Read+write together is a write.
                    is_wr_s      = grant_s ? m1_write : m0_write;
                    oor_s        = grant_s ? oor1_s : oor0_s;
                    state_s      = ISSUE;
                    // Writes are acknowledged while the RAM command is on the pins.
                    if (is_wr_s) begin
                        if (grant_s) begin
                            wait1_s = 1'b0;
                            err1_s  = oor_s;
                        end else begin
                            wait0_s = 1'b0;
                            err0_s  = oor_s;
                        end
                    end else begin
                        wait0_s = 1'b1;
                        wait1_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (is_wr_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = RDCAP;
                end
            end
            RDCAP: begin
                state_s = RDRESP;
                if (grant_r) begin
                    wait1_s = 1'b0;
                    err1_s  = oor_r;
                end else begin
                    wait0_s = 1'b0;
                    err0_s  = oor_r;
                end
            end
            RDRESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered waitrequest / err handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            m0_err         <= 1'b0;
            m1_err         <= 1'b0;
        end else begin
            m0_waitrequest <= wait0_s;
            m1_waitrequest <= wait1_s;
            m0_err         <= err0_s;
            m1_err         <= err1_s;
        end
    end

    // Read data capture; each master's readdata holds until its next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_readdata <= {DATA_W{1'b0}};
            m1_readdata <= {DATA_W{1'b0}};
        end else if (state_r == RDCAP) begin
            if (grant_r) begin
                m1_readdata <= oor_r ? {DATA_W{1'b0}} : ram_readdata;
            end else begin
                m0_readdata <= oor_r ? {DATA_W{1'b0}} : ram_readdata;
            end
        end else begin
            m0_readdata <= m0_readdata;
            m1_readdata <= m1_readdata;
        end
    end

    // RAM command pins; reset gates the strobes so a write caught in ISSUE never lands.
    always_comb begin
        ram_address    = {ADDR_W{1'b0}};
        ram_byteenable = {BE_W{1'b0}};
        ram_writedata  = {DATA_W{1'b0}};
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (state_r == ISSUE) begin
            if (grant_r) begin
                ram_address    = m1_address;
                ram_byteenable = m1_byteenable;
                ram_writedata  = m1_writedata;
            end else begin
                ram_address    = m0_address;
                ram_byteenable = m0_byteenable;
                ram_writedata  = m0_writedata;
            end
            if (!oor_r && !reset) begin
                ram_chipselect = 1'b1;
                ram_write      = is_wr_r;
            end else begin
                ram_chipselect = 1'b0;
                ram_write      = 1'b0;
            end
        end else begin
            ram_chipselect = 1'b0;
            ram_write      = 1'b0;
        end
    end

`ifdef RAM_ARB_ERRCNT_EN
    logic accept_err_s;

    assign accept_err_s = (((state_r == ISSUE) && is_wr_r) || (state_r == RDRESP)) && oor_r;

    // Saturating count of accepted out-of-range accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 16'h0000;
        end else if (accept_err_s && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end else begin
            err_count <= err_count;
        end
    end
`endif

endmodule

// File: tb/tb_nios_security_ram_arbiter.sv
// Directed, table-driven bench for nios_security_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_nios_security_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [10:0] m0_address, m1_address;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [7:0]  m0_byteenable, m1_byteenable;
    logic [63:0] m0_writedata, m1_writedata;
    logic [63:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_err, m1_err;
    logic [10:0] ram_address;
    logic [7:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [63:0] ram_writedata;
    logic [63:0] ram_readdata;
`ifdef RAM_ARB_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int prot_bad = 0;
    int oor_hits = 0;

    bit [63:0] mem [0:1249];

    nios_security_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .m0_err(m0_err),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest), .m1_err(m1_err),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
`ifdef RAM_ARB_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-lane writes, registered read data.
    always @(posedge clk) begin
        if (ram_chipselect && ram_address >= 11'd1250) oor_hits <= oor_hits + 1;
        if (ram_clken && ram_chipselect && ram_address < 11'd1250) begin
            if (ram_write) begin
                for (int i = 0; i < 8; i++)
                    if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
            end
            ram_readdata <= mem[ram_address];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit m, input bit rd, input bit wr, input logic [10:0] a,
                           input logic [7:0] be, input logic [63:0] d);
        if (m) begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end else begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end
    endtask

    // One transaction on one master; lat counts the request cycle as 1.
    task automatic txn(input bit m, input bit wr, input logic [10:0] a, input logic [7:0] be,
                       input logic [63:0] d, output int lat, output bit err,
                       output logic [63:0] rd, output logic [1:0] cswr);
        logic w, ow;
        @(negedge clk);
        set_req(m, !wr, wr, a, be, d);
        lat = 1; err = 1'b0; rd = 64'd0; cswr = 2'b00;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 2) cswr = {ram_chipselect, ram_write};
            w  = m ? m1_waitrequest : m0_waitrequest;
            ow = m ? m0_waitrequest : m1_waitrequest;
            if (!ow) prot_bad++;
            if (!w) break;
            if (m ? m1_err : m0_err) prot_bad++;
        end
        err = m ? m1_err : m0_err;
        rd  = m ? m1_readdata : m0_readdata;
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
    endtask

    typedef struct {
        bit          m;
        bit          wr;
        logic [10:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        bit          exp_err;
        logic [1:0]  exp_cswr;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int lat, n, g, k0, k1, t0, t1;
        bit err, a0, a1, d0, d1;
        logic [63:0] rd, rd0;
        logic [1:0] cswr;

        vecs[0]  = '{1'b0, 1'b1, 11'd5,    8'hFF, 64'h0123456789ABCDEF, 1'b0, 2'b11, 64'd0};
        vecs[1]  = '{1'b0, 1'b0, 11'd5,    8'hFF, 64'd0,                1'b0, 2'b10, 64'h0123456789ABCDEF};
        vecs[2]  = '{1'b1, 1'b0, 11'd7,    8'hFF, 64'd0,                1'b0, 2'b10, 64'd0};
        vecs[3]  = '{1'b1, 1'b1, 11'd7,    8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2'b11, 64'd0};
        vecs[4]  = '{1'b1, 1'b0, 11'd7,    8'hFF, 64'd0,                1'b0, 2'b10, 64'h00000000FFFFFFFF};
        vecs[5]  = '{1'b0, 1'b1, 11'd1250, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b1, 2'b00, 64'd0};
        vecs[6]  = '{1'b0, 1'b0, 11'd2047, 8'hFF, 64'd0,                1'b1, 2'b00, 64'd0};
        vecs[7]  = '{1'b0, 1'b1, 11'd1249, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 1'b0, 2'b11, 64'd0};
        vecs[8]  = '{1'b0, 1'b0, 11'd1249, 8'hFF, 64'd0,                1'b0, 2'b10, 64'hA5A5A5A5A5A5A5A5};
        vecs[9]  = '{1'b1, 1'b1, 11'd0,    8'h80, 64'h1122334455667788, 1'b0, 2'b11, 64'd0};
        vecs[10] = '{1'b1, 1'b0, 11'd0,    8'hFF, 64'd0,                1'b0, 2'b10, 64'h1100000000000000};
        vecs[11] = '{1'b0, 1'b0, 11'd0,    8'hFF, 64'd0,                1'b0, 2'b10, 64'h1100000000000000};

        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
        set_req(1'b1, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wait", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd3);
        check("rst_err", {62'd0, m0_err, m1_err}, 64'd0);
        check("rst_rdata0", m0_readdata, 64'd0);
        check("rst_rdata1", m1_readdata, 64'd0);
        check("rst_ram_ctl", {60'd0, ram_chipselect, ram_write, ram_clken, 1'b0}, 64'd2);
        check("rst_ram_bus", {45'd0, ram_address, ram_byteenable}, 64'd0);
        check("rst_ram_wd", ram_writedata, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].data, lat, err, rd, cswr);
            check($sformatf("v%0d_latency", i), 64'(lat), vecs[i].wr ? 64'd2 : 64'd4);
            check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].exp_err});
            check($sformatf("v%0d_cs_wr", i), {62'd0, cswr}, {62'd0, vecs[i].exp_cswr});
            if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        check("mem_oor_untouched", mem[1249], 64'hA5A5A5A5A5A5A5A5);
`ifdef RAM_ARB_ERRCNT_EN
        check("err_count", {48'd0, err_count}, 64'd2);
`endif

        // m1 read must not disturb m0's held readdata.
        txn(1'b1, 1'b0, 11'd5, 8'hFF, 64'd0, lat, err, rd, cswr);
        check("m1_rd5", rd, 64'h0123456789ABCDEF);
        check("m0_rdata_held", m0_readdata, 64'h1100000000000000);

        // Both masters hold writes continuously: strict alternation, m0 first.
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 11'd100, 8'hFF, 64'hA000000000000000);
        set_req(1'b1, 1'b0, 1'b1, 11'd200, 8'hFF, 64'hB000000000000000);
        n = 1; g = 0; k0 = 0; k1 = 0;
        while (g < 8 && n < 60) begin
            @(negedge clk);
            n++;
            a0 = !m0_waitrequest;
            a1 = !m1_waitrequest;
            if (a0 && a1) prot_bad++;
            if (a0 || a1) begin
                check($sformatf("alt%0d_who", g), {63'd0, a1}, 64'(g % 2));
                check($sformatf("alt%0d_cycle", g), 64'(n), 64'(2 + 2 * g));
                g++;
            end
            @(posedge clk); #1;
            if (g >= 8) begin
                set_req(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
                set_req(1'b1, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
            end else begin
                if (a0) begin
                    k0++;
                    set_req(1'b0, 1'b0, 1'b1, 11'(100 + k0), 8'hFF, 64'hA000000000000000 | 64'(k0));
                end
                if (a1) begin
                    k1++;
                    set_req(1'b1, 1'b0, 1'b1, 11'(200 + k1), 8'hFF, 64'hB000000000000000 | 64'(k1));
                end
            end
        end
        check("alt_grants", 64'(g), 64'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_mem0_%0d", i), mem[100 + i], 64'hA000000000000000 | 64'(i));
            check($sformatf("alt_mem1_%0d", i), mem[200 + i], 64'hB000000000000000 | 64'(i));
        end

        // m0 read, m1 write one cycle later: m1 waits out m0's read.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 11'd5, 8'hFF, 64'd0);
        n = 1;
        @(negedge clk);
        n = 2;
        set_req(1'b1, 1'b0, 1'b1, 11'd30, 8'hFF, 64'hC0FFEE00C0FFEE00);
        d0 = 1'b0; d1 = 1'b0; t0 = 0; t1 = 0; rd0 = 64'd0;
        while (!(d0 && d1) && n < 20) begin
            @(negedge clk);
            n++;
            a0 = !d0 && !m0_waitrequest;
            a1 = !d1 && !m1_waitrequest;
            if (a0) begin d0 = 1'b1; t0 = n; rd0 = m0_readdata; end
            if (a1) begin d1 = 1'b1; t1 = n; end
            @(posedge clk); #1;
            if (a0) set_req(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
            if (a1) set_req(1'b1, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
        end
        check("mix_m0_cycle", 64'(t0), 64'd4);
        check("mix_m0_rdata", rd0, 64'h0123456789ABCDEF);
        check("mix_m1_cycle", 64'(t1), 64'd6);
        check("mix_m1_mem", mem[30], 64'hC0FFEE00C0FFEE00);

        // Reset while an m1 read sits in RDCAP, then m1 reissues.
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 11'd7, 8'hFF, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rdcap_rst_wait", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd3);
        check("rdcap_rst_rdata1", m1_readdata, 64'd0);
        check("rdcap_rst_rdata0", m0_readdata, 64'd0);
        check("rdcap_rst_cs", {63'd0, ram_chipselect}, 64'd0);
        reset = 1'b0;
        n = 1;
        while (m1_waitrequest && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("reissue_cycle", 64'(n), 64'd4);
        check("reissue_rdata", m1_readdata, 64'h00000000FFFFFFFF);
        check("reissue_err", {63'd0, m1_err}, 64'd0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);

        // Reset during ISSUE of a write must keep the RAM untouched.
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 11'd20, 8'hFF, 64'h5555AAAA5555AAAA);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 11'd0, 8'h00, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check("issue_rst_wait", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd3);
        check("issue_rst_mem", mem[20], 64'd0);

        repeat (2) @(negedge clk);
        check("other_wait_and_err_rules", 64'(prot_bad), 64'd0);
        check("oor_chipselect", 64'(oor_hits), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
